// File: rtl/laser_cover_eval.sv
// Scoring stage for the two-circle laser placer: snoops the point stream, latches
// the centres on DONE_IN, then recounts coverage one point per cycle.
module laser_cover_eval #(
    parameter int unsigned NPTS      = 40,
    parameter int unsigned RADIUS_SQ = 16,
    parameter int unsigned CW        = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          DONE_IN,
    input  logic [CW-1:0] C1X,
    input  logic [CW-1:0] C1Y,
    input  logic [CW-1:0] C2X,
    input  logic [CW-1:0] C2Y,
    output logic [5:0]    COUNT,
    output logic [5:0]    COUNT_C1,
    output logic [5:0]    COUNT_C2,
    output logic          OUT_VALID,
    output logic          ERR,
    output logic          BUSY
);

    typedef enum logic [2:0] {StIdle, StLoad, StWaitDone, StEval, StReport} state_e;

    localparam logic [5:0]    LastIdx = 6'(NPTS - 1);
    localparam logic [2*CW:0] RadSq   = (2*CW+1)'(RADIUS_SQ);

    state_e        state_q, state_d;
    logic [5:0]    idx_q;
    logic [CW-1:0] mem_x [NPTS];
    logic [CW-1:0] mem_y [NPTS];
    logic [CW-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
    logic [5:0]    acc_c1_q, acc_c2_q, acc_u_q;
    logic [5:0]    acc_c1_d, acc_c2_d, acc_u_d;
    logic [5:0]    count_q, count_c1_q, count_c2_q;
    logic          err_q;
    logic          last_pt, wr_en, in1, in2;

    // Squared distance test; each square fits 2*CW bits, the sum needs one more.
    function automatic logic covered(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                     input logic [CW-1:0] cx, input logic [CW-1:0] cy);
        logic [CW-1:0]   dx, dy;
        logic [2*CW-1:0] sx, sy;
        logic [2*CW:0]   sum;
        dx  = (px >= cx) ? px - cx : cx - px;
        dy  = (py >= cy) ? py - cy : cy - py;
        sx  = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
        sy  = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
        sum = {1'b0, sx} + {1'b0, sy};
        return sum <= RadSq;
    endfunction

    assign last_pt  = (idx_q == LastIdx);
    assign wr_en    = IN_VALID && ((state_q == StIdle) || (state_q == StLoad && !DONE_IN));
    assign in1      = covered(mem_x[idx_q], mem_y[idx_q], c1x_q, c1y_q);
    assign in2      = covered(mem_x[idx_q], mem_y[idx_q], c2x_q, c2y_q);
    assign acc_c1_d = acc_c1_q + 6'(in1);
    assign acc_c2_d = acc_c2_q + 6'(in2);
    assign acc_u_d  = acc_u_q + 6'(in1 | in2);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (IN_VALID) state_d = StLoad;
            StLoad: begin
                if (DONE_IN)                    state_d = StIdle;
                else if (IN_VALID && last_pt)   state_d = StWaitDone;
            end
            StWaitDone: if (DONE_IN) state_d = StEval;
            StEval:     if (last_pt) state_d = StReport;
            StReport:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY      = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            StLoad, StWaitDone, StEval: BUSY = 1'b1;
            StReport:                   OUT_VALID = 1'b1;
            default:                    ;
        endcase
    end

    // Point buffer carries no reset; it is always rewritten before being read.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_x[idx_q] <= X;
            mem_y[idx_q] <= Y;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q      <= '0;
            err_q      <= 1'b0;
            c1x_q      <= '0;
            c1y_q      <= '0;
            c2x_q      <= '0;
            c2y_q      <= '0;
            acc_c1_q   <= '0;
            acc_c2_q   <= '0;
            acc_u_q    <= '0;
            count_q    <= '0;
            count_c1_q <= '0;
            count_c2_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (IN_VALID) begin
                        idx_q <= 6'd1;
                        err_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (DONE_IN) begin
                        err_q <= 1'b1;
                        idx_q <= '0;
                    end else if (IN_VALID) begin
                        idx_q <= last_pt ? 6'd0 : idx_q + 6'd1;
                    end
                end
                StWaitDone: begin
                    if (DONE_IN) begin
                        c1x_q    <= C1X;
                        c1y_q    <= C1Y;
                        c2x_q    <= C2X;
                        c2y_q    <= C2Y;
                        acc_c1_q <= '0;
                        acc_c2_q <= '0;
                        acc_u_q  <= '0;
                    end
                end
                StEval: begin
                    acc_c1_q <= acc_c1_d;
                    acc_c2_q <= acc_c2_d;
                    acc_u_q  <= acc_u_d;
                    idx_q    <= last_pt ? 6'd0 : idx_q + 6'd1;
                    // Publish with the last point folded in so counts appear with OUT_VALID.
                    if (last_pt) begin
                        count_q    <= acc_u_d;
                        count_c1_q <= acc_c1_d;
                        count_c2_q <= acc_c2_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign COUNT    = count_q;
    assign COUNT_C1 = count_c1_q;
    assign COUNT_C2 = count_c2_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_laser_cover_eval.sv
// Directed bench for laser_cover_eval with hand-computed coverage counts.
module tb_laser_cover_eval;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IN_VALID;
    logic [3:0] X, Y;
    logic       DONE_IN;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic [5:0] COUNT, COUNT_C1, COUNT_C2;
    logic       OUT_VALID, ERR, BUSY;

    int checks = 0;
    int errors = 0;

    logic [3:0] px [40];
    logic [3:0] py [40];

    laser_cover_eval dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_VALID (IN_VALID),
        .X        (X),
        .Y        (Y),
        .DONE_IN  (DONE_IN),
        .C1X      (C1X),
        .C1Y      (C1Y),
        .C2X      (C2X),
        .C2Y      (C2Y),
        .COUNT    (COUNT),
        .COUNT_C1 (COUNT_C1),
        .COUNT_C2 (COUNT_C2),
        .OUT_VALID(OUT_VALID),
        .ERR      (ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_all(input logic [3:0] x, input logic [3:0] y);
        for (int i = 0; i < 40; i++) begin
            px[i] = x;
            py[i] = y;
        end
    endtask

    task automatic fill_split();
        for (int i = 0; i < 40; i++) begin
            px[i] = (i < 20) ? 4'd0 : 4'd15;
            py[i] = (i < 20) ? 4'd0 : 4'd15;
        end
    endtask

    // Stall cycles drive (0,0) with IN_VALID low; a spurious store would skew the split counts.
    task automatic load_points(input int start, input int stall_at, input int stall_len);
        for (int i = start; i < 40; i++) begin
            if (i == stall_at) begin
                IN_VALID = 1'b0;
                X = 4'd0;
                Y = 4'd0;
                repeat (stall_len) step();
            end
            IN_VALID = 1'b1;
            X = px[i];
            Y = py[i];
            step();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic run_eval(input string tag, input logic [3:0] c1x, input logic [3:0] c1y,
                            input logic [3:0] c2x, input logic [3:0] c2y,
                            input int exp_u, input int exp_1, input int exp_2);
        int n;
        DONE_IN = 1'b1;
        C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
        step();
        DONE_IN = 1'b0;
        C1X = 4'd3; C1Y = 4'd11; C2X = 4'd6; C2Y = 4'd2;
        n = 1;
        while (!OUT_VALID && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, n, 41);
        check_eq({tag, "_count"}, int'(COUNT), exp_u);
        check_eq({tag, "_count_c1"}, int'(COUNT_C1), exp_1);
        check_eq({tag, "_count_c2"}, int'(COUNT_C2), exp_2);
        step();
        check_eq({tag, "_ov_pulse"}, int'(OUT_VALID), 0);
        check_eq({tag, "_busy_after"}, int'(BUSY), 0);
    endtask

    initial begin
        int pulses;
        RST_N = 1'b0; IN_VALID = 1'b0; X = '0; Y = '0; DONE_IN = 1'b0;
        C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
        repeat (3) step();
        check_eq("rst_count", int'(COUNT), 0);
        check_eq("rst_count_c1", int'(COUNT_C1), 0);
        check_eq("rst_count_c2", int'(COUNT_C2), 0);
        check_eq("rst_out_valid", int'(OUT_VALID), 0);
        check_eq("rst_err", int'(ERR), 0);
        check_eq("rst_busy", int'(BUSY), 0);
        RST_N = 1'b1;
        step();

        // All points on C1's centre.
        fill_all(4'd8, 4'd8);
        load_points(0, -1, 0);
        check_eq("wait_done_busy", int'(BUSY), 1);
        run_eval("center", 4'd8, 4'd8, 4'd0, 4'd0, 40, 40, 0);
        repeat (3) step();
        check_eq("hold_count", int'(COUNT), 40);

        // Radius boundary: dist^2 = 16 covered, 17 not.
        fill_all(4'd0, 4'd15);
        px[39] = 4'd12; py[39] = 4'd8;
        load_points(0, -1, 0);
        run_eval("rad16", 4'd8, 4'd8, 4'd0, 4'd0, 1, 1, 0);
        py[39] = 4'd9;
        load_points(0, -1, 0);
        run_eval("rad17", 4'd8, 4'd8, 4'd0, 4'd0, 0, 0, 0);

        // Split corners, then back-to-back with coincident centres.
        fill_split();
        load_points(0, -1, 0);
        run_eval("split", 4'd0, 4'd0, 4'd15, 4'd15, 40, 20, 20);
        load_points(0, -1, 0);
        run_eval("coinc", 4'd0, 4'd0, 4'd0, 4'd0, 20, 20, 20);

        // Five-cycle stall mid-load.
        load_points(0, 20, 5);
        run_eval("stall", 4'd0, 4'd0, 4'd15, 4'd15, 40, 20, 20);

        // Early DONE_IN after 10 points.
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1; X = 4'd8; Y = 4'd8;
            step();
        end
        IN_VALID = 1'b0;
        DONE_IN = 1'b1;
        step();
        DONE_IN = 1'b0;
        check_eq("early_err", int'(ERR), 1);
        check_eq("early_busy", int'(BUSY), 0);
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            if (OUT_VALID) pulses++;
            step();
        end
        check_eq("early_no_ov", pulses, 0);
        check_eq("early_keep_count", int'(COUNT), 40);
        check_eq("early_keep_c1", int'(COUNT_C1), 20);
        check_eq("early_keep_c2", int'(COUNT_C2), 20);
        check_eq("early_err_sticky", int'(ERR), 1);
        fill_all(4'd8, 4'd8);
        IN_VALID = 1'b1; X = px[0]; Y = py[0];
        step();
        check_eq("err_cleared", int'(ERR), 0);
        check_eq("err_clear_busy", int'(BUSY), 1);
        load_points(1, -1, 0);
        run_eval("after_err", 4'd8, 4'd8, 4'd8, 4'd8, 40, 40, 40);

        // Reset while evaluating index 20.
        load_points(0, -1, 0);
        DONE_IN = 1'b1;
        C1X = 4'd8; C1Y = 4'd8; C2X = 4'd0; C2Y = 4'd0;
        step();
        DONE_IN = 1'b0;
        repeat (20) step();
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("midrst_count", int'(COUNT), 0);
        check_eq("midrst_c1", int'(COUNT_C1), 0);
        check_eq("midrst_c2", int'(COUNT_C2), 0);
        check_eq("midrst_busy", int'(BUSY), 0);
        check_eq("midrst_ov", int'(OUT_VALID), 0);
        step();
        RST_N = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (OUT_VALID) pulses++;
            step();
        end
        check_eq("midrst_no_ov", pulses, 0);
        check_eq("midrst_busy_after", int'(BUSY), 0);
        fill_split();
        load_points(0, -1, 0);
        run_eval("post_rst", 4'd15, 4'd15, 4'd8, 4'd8, 20, 20, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/laser_cover_eval.md
Name: laser_cover_eval

Overview:
- Downstream scoring stage for the two-circle laser placement engine.
- Snoops the same 40-point X/Y input stream the placement engine loads, then latches the C1/C2 centres when the engine pulses DONE.
- Recounts, one point per cycle, how many points the two radius-4 circles cover: C1 alone, C2 alone, and the union.
- Used on-chip as a self-check and score reporter for each round.

Parameters:
- NPTS, 40, points per round.
- RADIUS_SQ, 16, squared circle radius; a point is covered when dx²+dy² <= RADIUS_SQ.
- CW, 4, coordinate width in bits.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  a point is present on X/Y this cycle.
- X  in  CW  point x coordinate.
- Y  in  CW  point y coordinate.
- DONE_IN  in  1  placement-engine DONE; the centres are valid in this cycle.
- C1X, C1Y  in  CW each  circle 1 centre.
- C2X, C2Y  in  CW each  circle 2 centre.
- COUNT  out  6  points covered by C1 or C2; a point counts once.
- COUNT_C1  out  6  points covered by C1.
- COUNT_C2  out  6  points covered by C2.
- OUT_VALID  out  1  one-cycle pulse; the counts are fresh.
- ERR  out  1  sticky; DONE_IN arrived before NPTS points were loaded.
- BUSY  out  1  high in LOAD, WAIT_DONE and EVAL.

Behaviour:
- Reset, asynchronous on RST_N low: state=IDLE; point index=0; COUNT, COUNT_C1, COUNT_C2 = 0; OUT_VALID=0; ERR=0; BUSY=0; latched centres=0. The point buffer is not reset.
- States: IDLE, LOAD, WAIT_DONE, EVAL, REPORT.
- IDLE:
  - IN_VALID=1: store X/Y at index 0, index=1, go to LOAD, clear ERR.
  - DONE_IN ignored.
- LOAD:
  - Each IN_VALID=1 cycle stores the point at the index and increments it; IN_VALID=0 cycles stall without a store.
  - When the NPTS-th point is stored, go to WAIT_DONE and reset the index to 0.
  - DONE_IN=1 in LOAD (with or without IN_VALID): set ERR=1, go to IDLE, no OUT_VALID, counts keep their previous values.
- WAIT_DONE:
  - IN_VALID ignored.
  - DONE_IN=1: latch C1X, C1Y, C2X, C2Y into internal registers, clear the three accumulators, go to EVAL.
- EVAL:
  - Each cycle evaluate point[index] against the latched centres.
  - dx = |px-cx| computed as a CW-bit unsigned difference, never a wrap.
  - dx² and dy² each fit 2·CW bits; their sum uses 2·CW+1 bits, 9 bits for CW=4.
  - in1 = (dx1²+dy1² <= RADIUS_SQ); in2 likewise for C2.
  - acc_c1 += in1; acc_c2 += in2; acc_u += (in1|in2).
  - Index increments each cycle. After index NPTS-1 is evaluated, go to REPORT.
  - Exactly NPTS EVAL cycles.
  - DONE_IN and IN_VALID ignored.
- REPORT, one cycle:
  - COUNT, COUNT_C1, COUNT_C2 <= accumulators; OUT_VALID=1.
  - Return to IDLE.
  - The counts hold until the next REPORT or reset.
  - An IN_VALID arriving in REPORT is not captured.
- Latency: DONE_IN sampled at the end of cycle k → EVAL in cycles k+1..k+NPTS → OUT_VALID=1 and new counts visible in cycle k+NPTS+1.
- The counts are registered outputs and are updated only in REPORT.
- Accumulators are 6 bits and cannot overflow, since NPTS=40 ≤ 63.
- Coincident centres (C1==C2): COUNT == COUNT_C1 == COUNT_C2.
- Reset asserted mid-LOAD or mid-EVAL: immediate return to IDLE with all outputs zero; the partial round is discarded.
- ERR clears only on reset or on the first IN_VALID accepted in IDLE.

Test Plan:
- All 40 points at (8,8); DONE_IN with C1=(8,8), C2=(0,0) → OUT_VALID 41 cycles after DONE_IN; COUNT=40, COUNT_C1=40, COUNT_C2=0.
- Radius boundary: 39 points at (0,15) plus one at (12,8), then repeat the round with (12,9) in place of (12,8); C1=(8,8), C2=(0,0) → first round COUNT=1 (dist²=16 is covered), second round COUNT=0 (dist²=17 is not).
- 20 points at (0,0) and 20 at (15,15); C1=(0,0), C2=(15,15) → COUNT=40, COUNT_C1=20, COUNT_C2=20. Swap to C1=C2=(0,0) → COUNT=20, COUNT_C1=20, COUNT_C2=20.
- IN_VALID held low for 5 cycles mid-load, then resumed → all 40 points captured, result identical to the unstalled run. DONE_IN after only 10 points → ERR=1, no OUT_VALID, BUSY=0; next round's first point clears ERR.
- RST_N pulsed low during EVAL index 20 → counts=0, OUT_VALID never pulses, BUSY=0. A full new round afterwards gives the correct counts.
- Back-to-back rounds: the second round's first point is presented in the cycle after REPORT → captured correctly, second result independent of the first.
